// File: rtl/dram_arbiter.sv
// Round-robin arbiter and access sequencer sharing one single-port DRAM among
// N_REQ cores: one strobe cycle per access, fixed read latency, completion pulse.
module dram_arbiter #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8,
  parameter int N_REQ  = 4,
  parameter int RD_LAT = 1
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        wr,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic [N_REQ*WIDTH-1:0]  wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic [WIDTH-1:0]        rdata,
  output logic                    busy,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [WIDTH-1:0]        mem_wdata,
  output logic                    mem_re,
  output logic                    mem_we,
  input  logic [WIDTH-1:0]        mem_rdata
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] w_idx;
  logic             w_wr;
  logic [CNT_W-1:0] cnt;

  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] cand;
  logic             found;

  logic [ADDR_W-1:0] addr_a  [N_REQ];
  logic [WIDTH-1:0]  wdata_a [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = wdata[i*WIDTH +: WIDTH];
  end

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

  // Search starts one past the last winner, so the last winner has lowest priority.
  // NOTE: every variable assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // NOTE: all state and outputs update with non-blocking assignments so every
  // right-hand side sees pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      ptr       <= IDX_W'(N_REQ - 1);
      w_idx     <= '0;
      w_wr      <= 1'b0;
      cnt       <= '0;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      gnt    <= '0;
      done   <= '0;
      mem_re <= 1'b0;
      mem_we <= 1'b0;

      case (state)
        IDLE: begin
          if (found) begin
            w_idx     <= win;
            w_wr      <= wr[win];
            ptr       <= win;
            mem_addr  <= addr_a[win];
            mem_wdata <= wdata_a[win];
            gnt       <= onehot(win);
            mem_we    <= wr[win];
            mem_re    <= !wr[win];
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          if (w_wr) begin
            done  <= onehot(w_idx);
            state <= DONE;
          end else begin
            cnt   <= CNT_W'(RD_LAT);
            state <= WAIT;
          end
        end

        WAIT: begin
          // The last WAIT cycle is exactly RD_LAT cycles after mem_re.
          if (cnt == CNT_W'(1)) begin
            rdata <= mem_rdata;
            cnt   <= '0;
            done  <= onehot(w_idx);
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: transaction-timeline reference model
// with directed scenarios and randomized request traffic.
module tb_dram_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int L  = 2;
  localparam int L3 = 3;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  // Main instance (RD_LAT = 2)
  logic [N-1:0]    req = '0, wr = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]    gnt, done;
  logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;
  logic            busy, mem_re, mem_we;

  // Second instance (RD_LAT = 3) for the reset-during-read scenario
  logic [N-1:0]    req3 = '0, wr3 = '0;
  logic [N*AW-1:0] addr3 = '0;
  logic [N*DW-1:0] wdata3 = '0;
  logic [N-1:0]    gnt3, done3;
  logic [DW-1:0]   rdata3, mem_wdata3, mem_rdata3;
  logic [AW-1:0]   mem_addr3;
  logic            busy3, mem_re3, mem_we3;

  dram_arbiter #(.WIDTH(DW), .ADDR_W(AW), .N_REQ(N), .RD_LAT(L)) u_dut (
    .Clk(Clk), .Rst(Rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  dram_arbiter #(.WIDTH(DW), .ADDR_W(AW), .N_REQ(N), .RD_LAT(L3)) u_dut3 (
    .Clk(Clk), .Rst(Rst), .req(req3), .wr(wr3), .addr(addr3), .wdata(wdata3),
    .gnt(gnt3), .done(done3), .rdata(rdata3), .busy(busy3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_re(mem_re3), .mem_we(mem_we3),
    .mem_rdata(mem_rdata3)
  );

  // DRAM models: data is valid exactly RD_LAT cycles after the read strobe,
  // and the inverted word is presented in every other cycle.
  logic [DW-1:0] dram  [256] = '{default: 8'h00};
  logic [DW-1:0] pipe  [L];
  logic [DW-1:0] pipe3 [L3];

  always @(posedge Clk) begin
    if (mem_we) dram[mem_addr] <= mem_wdata;
    pipe[0] <= mem_re ? dram[mem_addr] : ~dram[mem_addr];
    for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
    pipe3[0] <= mem_re3 ? (mem_addr3 ^ 8'h77) : 8'hC3;
    for (int s = 1; s < L3; s++) pipe3[s] <= pipe3[s-1];
  end
  assign mem_rdata  = pipe[L-1];
  assign mem_rdata3 = pipe3[L3-1];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: one access record with absolute cycle numbers.
  bit            acc_v = 1'b0;
  int            acc_t, acc_w, acc_end;
  bit            acc_wr;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  int            m_ptr = N - 1;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] ref_mem [256] = '{default: 8'h00};

  function automatic int rr_pick(input int p, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_cycle();
    logic [N-1:0] e_gnt, e_done;
    bit e_busy, e_we, e_re;
    int w;
    e_gnt = '0; e_done = '0; e_busy = 0; e_we = 0; e_re = 0;
    if (acc_v) begin
      if (cyc == acc_t + 1) begin
        m_addr = acc_addr;
        m_wdata = acc_wdata;
        e_gnt[acc_w] = 1'b1;
        e_we = acc_wr;
        e_re = !acc_wr;
        if (acc_wr) ref_mem[acc_addr] = acc_wdata;
      end
      if (cyc == acc_t + acc_end) begin
        e_done[acc_w] = 1'b1;
        if (!acc_wr) m_rdata = ref_mem[acc_addr];
      end
      e_busy = (cyc >= acc_t + 1) && (cyc <= acc_t + acc_end);
    end
    check("gnt", gnt, e_gnt);
    check("done", done, e_done);
    check("busy", busy, e_busy);
    check("mem_we", mem_we, e_we);
    check("mem_re", mem_re, e_re);
    check("mem_addr", mem_addr, m_addr);
    check("mem_wdata", mem_wdata, m_wdata);
    check("rdata", rdata, m_rdata);

    if (acc_v && cyc > acc_t + acc_end) acc_v = 1'b0;
    if (Rst) begin
      acc_v = 1'b0; m_ptr = N - 1; m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else if (!acc_v && req != '0) begin
      w = rr_pick(m_ptr, req);
      m_ptr = w;
      acc_v = 1'b1; acc_t = cyc; acc_w = w; acc_wr = wr[w];
      acc_addr = addr[w*AW +: AW]; acc_wdata = wdata[w*DW +: DW];
      acc_end = acc_wr ? 2 : 2 + L;
    end
  endtask

  // Requester behaviour: hold until gnt, then drop (or keep requesting if hold).
  bit [N-1:0] hold = '0;
  bit         rnd_mode = 1'b0;
  int         grants[$];

  task automatic randomize_fields(input int i);
    wr[i] = 1'($urandom_range(0, 1));
    addr[i*AW +: AW]  = 8'($urandom_range(0, 31));
    wdata[i*DW +: DW] = 8'($urandom);
  endtask

  task automatic step();
    @(negedge Clk);
    model_cycle();
    @(posedge Clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        grants.push_back(i);
        if (hold[i]) randomize_fields(i);
        else req[i] = 1'b0;
      end
    end
    if (rnd_mode) begin
      Rst = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          randomize_fields(i);
        end
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
  endtask

  task automatic wait_quiet(input int budget);
    for (int k = 0; k < budget && (req != '0 || busy); k++) step();
    check("quiet_timeout", {31'd0, busy | (|req)}, 32'd0);
  endtask

  task automatic wait_grants(input int n, input int budget);
    for (int k = 0; k < budget && grants.size() < n; k++) step();
    check("grant_count", grants.size(), n);
  endtask

  task automatic issue(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1; wr[i] = w; addr[i*AW +: AW] = a; wdata[i*DW +: DW] = d;
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    do_reset();
    check("rst_busy", busy, 1'b0);
    check("rst_gnt", gnt, '0);

    // Single write
    issue(1, 1'b1, 8'h3C, 8'hA5);
    step();
    check("w_gnt", gnt, 4'b0010);
    check("w_we", mem_we, 1'b1);
    check("w_addr", mem_addr, 8'h3C);
    check("w_wdata", mem_wdata, 8'hA5);
    step();
    check("w_done", done, 4'b0010);
    step();
    check("w_busy_low", busy, 1'b0);
    wait_quiet(20);

    // Seed 0x5E at 0x10, then single read on requester 2
    issue(0, 1'b1, 8'h10, 8'h5E);
    wait_quiet(20);
    issue(2, 1'b0, 8'h10, 8'h00);
    step();
    check("r_re", mem_re, 1'b1);
    check("r_gnt", gnt, 4'b0100);
    repeat (3) step();
    check("r_done", done, 4'b0100);
    check("r_rdata", rdata, 8'h5E);
    repeat (4) step();
    check("r_rdata_hold", rdata, 8'h5E);
    wait_quiet(20);

    // Simultaneous requests after reset
    do_reset();
    grants.delete();
    for (int i = 0; i < N; i++) begin req[i] = 1'b1; randomize_fields(i); end
    wait_grants(4, 100);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      check($sformatf("sim_order%0d", k), grants[k], k);
    wait_quiet(40);

    // Fairness and pointer wrap between requesters 0 and 3
    do_reset();
    grants.delete();
    hold = 4'b1001;
    req[0] = 1'b1; randomize_fields(0);
    req[3] = 1'b1; randomize_fields(3);
    wait_grants(8, 200);
    for (int k = 0; k < 8 && k < grants.size(); k++)
      check($sformatf("fair%0d", k), grants[k], (k % 2 == 0) ? 0 : 3);
    hold = '0;
    wait_quiet(60);

    // Idle stability
    repeat (20) step();
    check("idle_maddr", mem_addr, m_addr);
    check("idle_busy", busy, 1'b0);

    // RD_LAT=3 instance: complete read, then a read abandoned by reset in WAIT
    req3 = 4'b0100; wr3 = '0; addr3[2*AW +: AW] = 8'h22;
    step();
    check("r3_gnt", gnt3, 4'b0100);
    check("r3_re", mem_re3, 1'b1);
    check("r3_we", mem_we3, 1'b0);
    check("r3_wdata", mem_wdata3, 8'h00);
    req3 = '0;
    repeat (4) step();
    check("r3_done", done3, 4'b0100);
    check("r3_rdata", rdata3, 8'h22 ^ 8'h77);
    step();
    check("r3_idle", busy3, 1'b0);
    addr3[2*AW +: AW] = 8'h33;
    req3 = 4'b0100;
    step();
    check("r3b_gnt", gnt3, 4'b0100);
    req3 = '0;
    step();
    check("r3b_wait_busy", busy3, 1'b1);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    check("r3b_rst_busy", busy3, 1'b0);
    check("r3b_rst_rdata", rdata3, 8'h00);
    check("r3b_rst_re", mem_re3, 1'b0);
    check("r3b_rst_done", done3, '0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("r3b_no_done%0d", k), done3, '0);
    end
    req3 = 4'b0101; addr3[0 +: AW] = 8'h01; addr3[2*AW +: AW] = 8'h02;
    step();
    check("r3_prio_after_rst", gnt3, 4'b0001);
    req3 = '0;
    repeat (10) step();

    // Randomized traffic with occasional resets
    rnd_mode = 1'b1;
    repeat (800) step();
    rnd_mode = 1'b0;
    Rst = 1'b0;
    wait_quiet(200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Round-robin arbiter and access sequencer that shares the single-port data DRAM among `N_REQ` processor cores. It sits between the cores' `DRAM_addr`, `DRAM_dataOut`, `DRAM_dataIn`, `memREAD` and `memWRITE` signals and the one physical DRAM port. It serialises requests, drives the memory strobes for exactly one cycle per access, waits out the memory read latency, and returns read data with a completion pulse.

## Interface
Parameters:
- `WIDTH`, 8: data width.
- `ADDR_W`, 8: address width.
- `N_REQ`, 4: number of requesters, 2..8.
- `RD_LAT`, 1: cycles from `mem_re` to valid `mem_rdata`, 1..4. A value of 0 is not supported.

Ports:
- `Clk` in 1: single clock. All logic is rising-edge.
- `Rst` in 1: reset, synchronous, active-high.
- `req` in N_REQ: access request, one bit per core.
- `wr` in N_REQ: 1 = write, 0 = read. Meaningful only while the matching `req` bit is high.
- `addr` in N_REQ*ADDR_W: requester i occupies `[i*ADDR_W +: ADDR_W]`.
- `wdata` in N_REQ*WIDTH: requester i occupies `[i*WIDTH +: WIDTH]`.
- `gnt` out N_REQ: one-hot, one-cycle pulse when a request is accepted.
- `done` out N_REQ: one-hot, one-cycle pulse when the access completes.
- `rdata` out WIDTH: shared read data. Valid in the `done` cycle of a read and held until the next read completes.
- `busy` out 1: high in every state except IDLE.
- `mem_addr` out ADDR_W: DRAM address.
- `mem_wdata` out WIDTH: DRAM write data.
- `mem_re` out 1: DRAM read strobe.
- `mem_we` out 1: DRAM write strobe.
- `mem_rdata` in WIDTH: DRAM read data.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and DONE. Every output is registered.
- IDLE: when any `req` bit is high, pick the winner by round-robin.
  - Search order is `ptr+1, ptr+2, …` modulo N_REQ. The first set bit wins.
  - Latch the winner index, `wr`, `addr` and `wdata`, set `ptr` to the winner, then go to ISSUE.
  - When no `req` bit is high, stay in IDLE.
- ISSUE: lasts one cycle.
  - `gnt[w]` = 1.
  - `mem_addr` and `mem_wdata` show the latched values.
  - `mem_we` = 1 for a write, `mem_re` = 1 for a read.
  - Next state: DONE for a write, WAIT for a read.
- WAIT: lasts RD_LAT cycles, counted by a down-counter loaded in ISSUE.
  - On the final WAIT edge, capture `mem_rdata` into `rdata`, then go to DONE.
- DONE: lasts one cycle. `done[w]` = 1, then return to IDLE.
- `mem_addr` and `mem_wdata` hold their last value outside ISSUE. The strobes are 0 outside ISSUE.
- `req`, `wr`, `addr` and `wdata` are sampled only in IDLE. Requesters hold them stable until `gnt`.
- A `req` bit still high when the FSM re-enters IDLE counts as a new request.
- A `req` bit that rises and falls while the FSM is not in IDLE is lost. This is the requester's responsibility.

## Timing
- Request sampled in IDLE at cycle T:
  - `gnt` and the memory strobe appear at T+1.
  - A write's `done` appears at T+2. Writes take 3 cycles per access.
  - A read's `done` and `rdata` appear at T+2+RD_LAT. Reads take 3+RD_LAT cycles.
- There is no bypass and no back-to-back issue. Each access passes through IDLE again.
- Simultaneous requests: exactly one wins per IDLE cycle. The others wait, and each is served within N_REQ accesses.
- Reset values:
  - State is IDLE.
  - `ptr` = N_REQ-1, so requester 0 is first in priority after reset.
  - `gnt`, `done`, `busy`, `mem_re` and `mem_we` are all 0.
  - `mem_addr`, `mem_wdata` and `rdata` are 0.
  - The WAIT counter is 0.
- Reset mid-operation: any in-flight access is abandoned.
  - No `done` is issued for it. `rdata` is cleared.
  - The strobes are 0 in the cycle after the reset edge.
  - `Rst` overrides every other input on the same edge.
- `ptr` wraps from N_REQ-1 to 0.

## Test plan
- Single write:
  - Stimulus: reset, then `req[1]`, `wr[1]` = 1, addr 0x3C, wdata 0xA5.
  - Response: `gnt[1]` and `mem_we` with `mem_addr` 0x3C and `mem_wdata` 0xA5 at T+1. `done[1]` at T+2. `busy` low at T+3.
- Single read with RD_LAT=2:
  - Stimulus: `req[2]` read of addr 0x10, memory model returns 0x5E.
  - Response: `mem_re` at T+1. `done[2]` at T+4 with `rdata` = 0x5E. `rdata` still 0x5E at T+8.
- Simultaneous requests:
  - Stimulus: all 4 `req` bits high after reset, each dropped on its own `gnt`.
  - Response: grant order 0, 1, 2, 3. Exactly one `gnt` bit high per pulse.
- Fairness and wrap:
  - Stimulus: `req[0]` and `req[3]` held high for 8 accesses.
  - Response: grants alternate 0, 3, 0, 3, … and `ptr` wraps correctly.
- Reset mid-read:
  - Stimulus: assert `Rst` in WAIT with RD_LAT=3.
  - Response: no `done` pulse, `rdata` = 0, state IDLE, and after reset requester 0 wins against requester 2.
- Idle stability:
  - Stimulus: `req` = 0 for 20 cycles.
  - Response: `busy`, the strobes, `gnt` and `done` stay 0, and `mem_addr` is unchanged.
